// File: rtl/crc3p_frame_ctrl.sv
// Frame sequencer for the 3-parallel CRC datapath: takes message words over valid/ready,
// folds PAR bits per cycle into the CRC, and presents the remainder after the last word.
module crc3p_frame_ctrl #(
    parameter int              DATA_W = 9,
    parameter int              PAR    = 3,
    parameter int              CRC_W  = 4,
    parameter logic [CRC_W-1:0] POLY  = 4'h3,
    parameter logic [CRC_W-1:0] INIT  = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy
);

    localparam int NCHUNK = DATA_W / PAR;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

    state_t             state;
    logic [DATA_W-1:0]  word_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt;
    logic [CRC_W-1:0]   crc;

    // PAR serial LFSR steps, chunk MSB first; message pre-multiplied by x^CRC_W
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic [PAR-1:0]   d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = PAR - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            word_q <= '0;
            last_q <= 1'b0;
            cnt    <= '0;
            crc    <= INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_q <= in_data;
                        last_q <= in_last;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // word register shifts left so the next chunk is always at the top
                    crc    <= crc_step(crc, word_q[DATA_W-1 -: PAR]);
                    word_q <= word_q << PAR;
                    if (cnt == CNT_W'(NCHUNK - 1)) begin
                        cnt   <= '0;
                        state <= last_q ? RESULT : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (crc_ready) begin
                        crc   <= INIT;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign crc_valid = (state == RESULT);
    assign busy      = (state != IDLE);
    assign crc_out   = crc;

endmodule
